// File: rtl/lockpick_result_monitor.sv
// lockpick_result_monitor
//   Captures 32-byte (FRAME_BYTES) result frames from the lockpick core stream,
//   classifies each frame on the fly against the win / lockout / error
//   patterns, cross-checks the verdict with the core status, keeps saturating
//   outcome counters and holds the last complete frame for sequential readback.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   in_valid/in_data  - result byte stream, byte 0 first
//   in_status         - core status, sampled with the final byte of a frame
//   rd_req            - read next byte of the held frame (honoured in HOLD)
//   rd_data/rd_valid  - read return, one cycle after the request
//   frame_done        - one-cycle pulse when a frame has been classified
//   verdict           - 10 win, 11 lockout, 01 error, 00 unrecognised
//   mismatch, gap_err - sticky error flags
//   win_cnt, lock_cnt, err_cnt - saturating outcome counters
module lockpick_result_monitor #(
    parameter int unsigned FRAME_BYTES = 32,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic [1:0]       in_status,
    input  logic             rd_req,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             frame_done,
    output logic [1:0]       verdict,
    output logic             mismatch,
    output logic             gap_err,
    output logic [CNT_W-1:0] win_cnt,
    output logic [CNT_W-1:0] lock_cnt,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int unsigned      IDX_W    = $clog2(FRAME_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DONE    = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d, rptr_q, rptr_d, wr_idx_c;
    logic [2:0]       flags_q, flags_d, match_c;   // {win, lockout, error}
    logic [1:0]       status_q, status_d, verdict_q, verdict_d, class_c;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d, frame_done_q, frame_done_d;
    logic             mismatch_q, mismatch_d, gap_err_q, gap_err_d;
    logic             held_q, held_d, start_c, commit_c;
    logic [CNT_W-1:0] win_cnt_q, win_cnt_d, lock_cnt_q, lock_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [7:0]       shadow_q    [FRAME_BYTES];
    logic [7:0]       frame_buf_q [FRAME_BYTES];

    // Byte position and per-pattern match of the incoming byte.
    // Every state outside CAPTURE treats a valid byte as byte 0 of a new frame.
    // All three patterns repeat every two bytes, so only the position parity matters.
    always_comb begin
        start_c  = in_valid && (state_q != S_CAPTURE);
        wr_idx_c = start_c ? '0 : idx_q;
        match_c  = {in_data == (wr_idx_c[0] ? 8'hFA : 8'hCE),
                    in_data == (wr_idx_c[0] ? 8'hDE : 8'hAD),
                    in_data == (wr_idx_c[0] ? 8'hBA : 8'hD0)};
    end

    // Frame class from the match flags; exactly one surviving flag names the class.
    always_comb begin
        unique case (flags_q)
            3'b100:  class_c = 2'b10;
            3'b010:  class_c = 2'b11;
            3'b001:  class_c = 2'b01;
            default: class_c = 2'b00;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic. An aborted frame falls back to HOLD when a committed
    // frame exists so that it stays readable; otherwise back to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (in_valid) state_d = S_CAPTURE;
            S_CAPTURE: begin
                if (!in_valid)                 state_d = held_q ? S_HOLD : S_IDLE;
                else if (idx_q == LAST_IDX)    state_d = S_DONE;
            end
            S_DONE:    state_d = in_valid ? S_CAPTURE : S_HOLD;
            S_HOLD:    if (in_valid) state_d = S_CAPTURE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Datapath / output next values.
    always_comb begin
        idx_d        = idx_q;
        flags_d      = flags_q;
        status_d     = status_q;
        verdict_d    = verdict_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = 1'b0;
        frame_done_d = 1'b0;
        rptr_d       = rptr_q;
        mismatch_d   = mismatch_q;
        gap_err_d    = gap_err_q;
        held_d       = held_q;
        win_cnt_d    = win_cnt_q;
        lock_cnt_d   = lock_cnt_q;
        err_cnt_d    = err_cnt_q;
        commit_c     = 1'b0;

        if (in_valid) begin
            flags_d = (start_c ? 3'b111 : flags_q) & match_c;
            if (wr_idx_c == LAST_IDX) begin
                idx_d    = '0;
                status_d = in_status;
            end else begin
                idx_d = wr_idx_c + 1'b1;
            end
        end else if (state_q == S_CAPTURE) begin
            gap_err_d = 1'b1;
            idx_d     = '0;
        end

        if (state_q == S_DONE) begin
            frame_done_d = 1'b1;
            verdict_d    = class_c;
            commit_c     = 1'b1;
            rptr_d       = '0;
            held_d       = 1'b1;
            if ((class_c == 2'b00) || (class_c != status_q)) mismatch_d = 1'b1;
            unique case (class_c)
                2'b10:   if (win_cnt_q  != CNT_MAX) win_cnt_d  = win_cnt_q  + 1'b1;
                2'b11:   if (lock_cnt_q != CNT_MAX) lock_cnt_d = lock_cnt_q + 1'b1;
                default: if (err_cnt_q  != CNT_MAX) err_cnt_d  = err_cnt_q  + 1'b1;
            endcase
        end

        // Capture has priority over a read in the same HOLD cycle.
        if ((state_q == S_HOLD) && rd_req && !in_valid) begin
            rd_data_d  = frame_buf_q[rptr_q];
            rd_valid_d = 1'b1;
            rptr_d     = (rptr_q == LAST_IDX) ? '0 : rptr_q + 1'b1;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q        <= '0;
            flags_q      <= '0;
            status_q     <= '0;
            verdict_q    <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
            rptr_q       <= '0;
            mismatch_q   <= 1'b0;
            gap_err_q    <= 1'b0;
            held_q       <= 1'b0;
            win_cnt_q    <= '0;
            lock_cnt_q   <= '0;
            err_cnt_q    <= '0;
        end else begin
            idx_q        <= idx_d;
            flags_q      <= flags_d;
            status_q     <= status_d;
            verdict_q    <= verdict_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            frame_done_q <= frame_done_d;
            rptr_q       <= rptr_d;
            mismatch_q   <= mismatch_d;
            gap_err_q    <= gap_err_d;
            held_q       <= held_d;
            win_cnt_q    <= win_cnt_d;
            lock_cnt_q   <= lock_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    // Frame storage: bytes land in the shadow, committed whole in DONE.
    // A byte 0 arriving in DONE overwrites shadow[0] after the commit reads it.
    always_ff @(posedge clk) begin
        if (in_valid) shadow_q[wr_idx_c] <= in_data;
        if (commit_c) frame_buf_q <= shadow_q;
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign frame_done = frame_done_q;
    assign verdict    = verdict_q;
    assign mismatch   = mismatch_q;
    assign gap_err    = gap_err_q;
    assign win_cnt    = win_cnt_q;
    assign lock_cnt   = lock_cnt_q;
    assign err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_lockpick_result_monitor.sv
// Testbench for lockpick_result_monitor: directed scenarios plus randomized
// frames, checked every cycle against a frame-level reference model.
`timescale 1ns/1ps
module tb_lockpick_result_monitor;
    localparam int FB = 32;
    localparam int CW = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst, in_valid, rd_req;
    logic [7:0]    in_data;
    logic [1:0]    in_status;
    logic [7:0]    rd_data;
    logic          rd_valid, frame_done, mismatch, gap_err;
    logic [1:0]    verdict;
    logic [CW-1:0] win_cnt, lock_cnt, err_cnt;

    lockpick_result_monitor #(.FRAME_BYTES(FB), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_status(in_status), .rd_req(rd_req), .rd_data(rd_data),
        .rd_valid(rd_valid), .frame_done(frame_done), .verdict(verdict),
        .mismatch(mismatch), .gap_err(gap_err), .win_cnt(win_cnt),
        .lock_cnt(lock_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // ---------------- reference model (frame level) ----------------
    logic [7:0] cur[$];
    logic [7:0] pend_frame[FB];
    logic [7:0] held[FB];
    logic [1:0] pend_st;
    int         done_pending, reading_ok, has_held, rptr;
    int         win_n, lock_n, err_n;
    logic       exp_fd, exp_rv, exp_mm, exp_gap;
    logic [7:0] exp_rd;
    logic [1:0] exp_verdict;
    int         cyc = 0, last_done = -1, prev_done = -1;

    function automatic logic [7:0] pat(input int k, input int i);
        case (k)
            0:       return (i % 2) ? 8'hFA : 8'hCE;
            1:       return (i % 2) ? 8'hDE : 8'hAD;
            2:       return (i % 2) ? 8'hBA : 8'hD0;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [1:0] classify();
        int         hits = 0;
        logic [1:0] c = 2'b00;
        logic [1:0] code [3] = '{2'b10, 2'b11, 2'b01};
        for (int k = 0; k < 3; k++) begin
            bit ok = 1'b1;
            for (int i = 0; i < FB; i++) if (pend_frame[i] != pat(k, i)) ok = 1'b0;
            if (ok) begin hits++; c = code[k]; end
        end
        return (hits == 1) ? c : 2'b00;
    endfunction

    function automatic int sat(input int n);
        return (n > CMAX) ? CMAX : n;
    endfunction

    task automatic model_reset();
        cur.delete();
        done_pending = 0; reading_ok = 0; has_held = 0; rptr = 0;
        win_n = 0; lock_n = 0; err_n = 0;
        exp_fd = 0; exp_rv = 0; exp_mm = 0; exp_gap = 0; exp_rd = 8'h00; exp_verdict = 2'b00;
    endtask

    task automatic model_step();
        logic [1:0] c;
        exp_fd = 0; exp_rv = 0;
        if (rst) begin model_reset(); return; end
        if (done_pending != 0) begin
            c = classify();
            exp_verdict = c;
            if (c == 2'b10) win_n++; else if (c == 2'b11) lock_n++; else err_n++;
            if (c == 2'b00 || c != pend_st) exp_mm = 1;
            for (int i = 0; i < FB; i++) held[i] = pend_frame[i];
            has_held = 1; rptr = 0; exp_fd = 1; done_pending = 0;
            if (in_valid) begin cur.push_back(in_data); reading_ok = 0; end
            else reading_ok = 1;
        end else if (cur.size() > 0) begin
            if (in_valid) begin
                cur.push_back(in_data);
                if (cur.size() == FB) begin
                    for (int i = 0; i < FB; i++) pend_frame[i] = cur[i];
                    pend_st = in_status; done_pending = 1; cur.delete();
                end
            end else begin
                exp_gap = 1; cur.delete(); reading_ok = has_held;
            end
        end else if (in_valid) begin
            cur.push_back(in_data); reading_ok = 0;
        end else if (reading_ok != 0 && rd_req) begin
            exp_rd = held[rptr]; exp_rv = 1; rptr = (rptr + 1) % FB;
        end
    endtask

    // One clock: model follows the sampled inputs, outputs checked 1 ns later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        check("frame_done", 32'(frame_done), 32'(exp_fd));
        check("verdict",    32'(verdict),    32'(exp_verdict));
        check("mismatch",   32'(mismatch),   32'(exp_mm));
        check("gap_err",    32'(gap_err),    32'(exp_gap));
        check("win_cnt",    32'(win_cnt),    32'(sat(win_n)));
        check("lock_cnt",   32'(lock_cnt),   32'(sat(lock_n)));
        check("err_cnt",    32'(err_cnt),    32'(sat(err_n)));
        check("rd_valid",   32'(rd_valid),   32'(exp_rv));
        check("rd_data",    32'(rd_data),    32'(exp_rd));
        if (frame_done) begin prev_done = last_done; last_done = cyc; end
    endtask

    // kind: 0 win, 1 lockout, 2 error, 3 random bytes, 4 win with one corrupt byte
    task automatic send_frame(input int kind, input logic [1:0] st, input int nbytes);
        int j;
        logic [7:0] b;
        j = $urandom_range(0, FB - 1);
        for (int i = 0; i < nbytes; i++) begin
            if (kind <= 2)      b = pat(kind, i);
            else if (kind == 3) b = 8'($urandom);
            else                b = (i == j) ? (pat(0, i) ^ 8'h01) : pat(0, i);
            in_valid  = 1'b1;
            in_data   = b;
            in_status = (i == nbytes - 1) ? st : 2'($urandom);
            rd_req    = 1'($urandom);
            tick();
        end
    endtask

    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0; in_data = 8'($urandom); rd_req = rr;
            tick();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; rd_req = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int nb, kind, idl;
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_status = 2'b00; rd_req = 1'b0;
        model_reset();
        tick(); tick();
        check("rst_verdict", 32'(verdict), 32'h0);
        check("rst_win_cnt", 32'(win_cnt), 32'h0);
        rst = 1'b0;
        rd_req = 1'b1; in_valid = 1'b0;
        tick();                                   // read before any frame: ignored

        // Single win frame.
        send_frame(0, 2'b10, FB);
        idle(2, 1'b0);
        check("win_verdict", 32'(verdict), 32'h2);
        check("win_count",   32'(win_cnt), 32'h1);

        // Lockout, error, then an unrecognised frame.
        do_reset();
        send_frame(1, 2'b11, FB); idle(1, 1'b0);
        send_frame(2, 2'b01, FB); idle(1, 1'b0);
        for (int i = 0; i < FB; i++) begin
            in_valid = 1'b1; in_data = (i % 2) ? 8'hAD : 8'hDE; in_status = 2'b11; rd_req = 1'b0;
            tick();
        end
        idle(2, 1'b0);
        check("lock_count",  32'(lock_cnt), 32'h1);
        check("err_count",   32'(err_cnt),  32'h2);
        check("unrec_verd",  32'(verdict),  32'h0);
        check("unrec_mm",    32'(mismatch), 32'h1);

        // Win frame, then 40 back-to-back reads with wrap.
        send_frame(0, 2'b10, FB); idle(1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            in_valid = 1'b0; rd_req = 1'b1;
            tick();
            if (i == 32) check("rd_wrap", 32'(rd_data), 32'hCE);
        end

        // Aborted frame after 10 bytes keeps the held frame and counters.
        send_frame(1, 2'b11, 10);
        idle(1, 1'b0);
        check("gap_flag", 32'(gap_err), 32'h1);
        idle(8, 1'b1);

        // Back-to-back frames through the DONE cycle.
        send_frame(0, 2'b10, FB);
        send_frame(1, 2'b11, FB);
        idle(2, 1'b0);
        check("b2b_spacing", 32'(last_done - prev_done), 32'd32);
        check("b2b_verdict", 32'(verdict), 32'h3);

        // Randomized frames, gaps, reads and idle spacing.
        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 4);
            nb   = ($urandom_range(0, 5) == 0) ? $urandom_range(1, FB - 1) : FB;
            send_frame(kind, 2'($urandom), nb);
            idl  = $urandom_range((nb < FB) ? 1 : 0, 4);
            for (int k = 0; k < idl; k++) idle(1, 1'($urandom));
        end

        // Counter saturation.
        do_reset();
        for (int f = 0; f < 256; f++) send_frame(0, 2'b10, FB);
        idle(1, 1'b0);
        check("win_sat", 32'(win_cnt), 32'd255);

        // Asynchronous reset in the middle of a frame.
        send_frame(1, 2'b11, 15);
        #2 rst = 1'b1;
        #1;
        check("arst_win_cnt",  32'(win_cnt),    32'h0);
        check("arst_verdict",  32'(verdict),    32'h0);
        check("arst_fdone",    32'(frame_done), 32'h0);
        check("arst_rd_data",  32'(rd_data),    32'h0);
        in_valid = 1'b0; rd_req = 1'b0;
        tick();
        rst = 1'b0;
        idle(3, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
